// File: rtl/nott_sched_pkg.sv
// Shared types and default constants for the NOT-T cell pulse scheduler.
package nott_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_DATA    = 3'd1,
      ST_SETUP   = 3'd2,
      ST_CLOCK   = 3'd3,
      ST_CAPTURE = 3'd4,
      ST_RESP    = 3'd5
   } sched_state_e;

   localparam int DEF_NREQ      = 2;
   localparam int DEF_SETUP_CYC = 2;
   localparam int DEF_WIN_CYC   = 4;

   // Larger of two integers, used to size the shared down-counter.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/nott_pulse_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among valid requesters, starting the
// search at the requester after the last one granted.
module rr_arbiter
   import nott_sched_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   localparam int IW  = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic            advance,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   grant_idx,
   output logic            grant_any
);

   logic [IW-1:0]   ptr_r;
   logic [IW:0]     sum_s;
   logic [IW-1:0]   cand_s;
   logic [IW-1:0]   idx_s;
   logic            found_s;
   logic [NREQ-1:0] grant_s;
   logic [IW-1:0]   ptr_next_s;

   // Scan requesters from the pointer upward (wrapping) and pick the first valid one.
   always_comb begin
      grant_s = '0;
      idx_s   = '0;
      found_s = 1'b0;
      sum_s   = '0;
      cand_s  = '0;
      for (int i = 0; i < NREQ; i++) begin
         sum_s = {1'b0, ptr_r} + (IW+1)'(i);
         if (sum_s >= (IW+1)'(NREQ)) begin
            cand_s = IW'(sum_s - (IW+1)'(NREQ));
         end else begin
            cand_s = sum_s[IW-1:0];
         end
         if (!found_s && req[cand_s]) begin
            found_s = 1'b1;
            idx_s   = cand_s;
         end else begin
            found_s = found_s;
         end
      end
      grant_s[idx_s] = found_s;
   end

   assign ptr_next_s = (idx_s == IW'(NREQ - 1)) ? '0 : (idx_s + IW'(1));
   assign grant      = grant_s;
   assign grant_idx  = idx_s;
   assign grant_any  = found_s;

   // Priority pointer moves past the granted requester only when a handshake completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_r <= '0;
      end else if (advance && found_s) begin
         ptr_r <= ptr_next_s;
      end else begin
         ptr_r <= ptr_r;
      end
   end

endmodule

// File: rtl/nott_pulse_scheduler.sv
// Shares one clocked RSFQ NOT-T cell between requesters: inject data, wait
// setup, clock the cell, capture its output window and report the result.
module nott_pulse_scheduler
   import nott_sched_pkg::*;
#(
   parameter int NREQ      = DEF_NREQ,
   parameter int SETUP_CYC = DEF_SETUP_CYC,
   parameter int WIN_CYC   = DEF_WIN_CYC,
   localparam int IW       = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req_valid,
   input  logic [NREQ-1:0] req_data,
   output logic [NREQ-1:0] req_ready,
   output logic            cell_in,
   output logic            cell_clk,
   input  logic            cell_out,
   output logic            rsp_valid,
   output logic [IW-1:0]   rsp_id,
   output logic            rsp_data,
   output logic            rsp_err,
   output logic            stray_pulse
);

   localparam int CNT_MAX = max_int(SETUP_CYC, WIN_CYC);
   localparam int CW      = $clog2(CNT_MAX + 1);

   sched_state_e    state_r, state_s;
   logic [CW-1:0]   cnt_r, cnt_s;
   logic [IW-1:0]   id_r, id_s;
   logic            data_r, data_s;
   logic            flag_r, flag_s;
   logic            cell_in_r, cell_in_s;
   logic            cell_clk_r, cell_clk_s;
   logic            rsp_valid_r, rsp_valid_s;
   logic [IW-1:0]   rsp_id_r, rsp_id_s;
   logic            rsp_data_r, rsp_data_s;
   logic            rsp_err_r, rsp_err_s;
   logic            stray_r;

   logic [NREQ-1:0] grant_s;
   logic [IW-1:0]   grant_idx_s;
   logic            grant_any_s;
   logic            handshake_s;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req_valid),
      .advance   (handshake_s),
      .grant     (grant_s),
      .grant_idx (grant_idx_s),
      .grant_any (grant_any_s)
   );

   assign handshake_s = (state_r == ST_IDLE) && grant_any_s;
   assign req_ready   = (state_r == ST_IDLE) ? grant_s : '0;

   // Next-state, counter, latches and next registered outputs of the sequencer.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      id_s    = id_r;
      data_s  = data_r;
      flag_s  = flag_r;
      case (state_r)
         ST_IDLE: begin
            if (handshake_s) begin
               id_s    = grant_idx_s;
               data_s  = req_data[grant_idx_s];
               state_s = ST_DATA;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_DATA: begin
            cnt_s   = CW'(SETUP_CYC - 1);
            state_s = ST_SETUP;
         end
         ST_SETUP: begin
            if (cnt_r == '0) begin
               state_s = ST_CLOCK;
            end else begin
               cnt_s = cnt_r - CW'(1);
            end
         end
         ST_CLOCK: begin
            flag_s  = 1'b0;
            cnt_s   = CW'(WIN_CYC - 1);
            state_s = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            flag_s = flag_r | cell_out;
            if (cnt_r == '0) begin
               state_s = ST_RESP;
            end else begin
               cnt_s = cnt_r - CW'(1);
            end
         end
         ST_RESP: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they appear registered in the matching cycle.
      cell_in_s   = (state_s == ST_DATA) && data_s;
      cell_clk_s  = (state_s == ST_CLOCK);
      rsp_valid_s = (state_s == ST_RESP);
      rsp_id_s    = rsp_valid_s ? id_s : '0;
      rsp_data_s  = rsp_valid_s && flag_s;
      rsp_err_s   = rsp_valid_s && (flag_s == data_s);
   end

   // Sequencer state, counter, transaction latches and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         cnt_r       <= '0;
         id_r        <= '0;
         data_r      <= 1'b0;
         flag_r      <= 1'b0;
         cell_in_r   <= 1'b0;
         cell_clk_r  <= 1'b0;
         rsp_valid_r <= 1'b0;
         rsp_id_r    <= '0;
         rsp_data_r  <= 1'b0;
         rsp_err_r   <= 1'b0;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         id_r        <= id_s;
         data_r      <= data_s;
         flag_r      <= flag_s;
         cell_in_r   <= cell_in_s;
         cell_clk_r  <= cell_clk_s;
         rsp_valid_r <= rsp_valid_s;
         rsp_id_r    <= rsp_id_s;
         rsp_data_r  <= rsp_data_s;
         rsp_err_r   <= rsp_err_s;
      end
   end

   // Sticky flag for cell output seen outside the capture window (including the clock cycle).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stray_r <= 1'b0;
      end else begin
         stray_r <= stray_r | (cell_out && (state_r != ST_CAPTURE));
      end
   end

   assign cell_in     = cell_in_r;
   assign cell_clk    = cell_clk_r;
   assign rsp_valid   = rsp_valid_r;
   assign rsp_id      = rsp_id_r;
   assign rsp_data    = rsp_data_r;
   assign rsp_err     = rsp_err_r;
   assign stray_pulse = stray_r;

endmodule

// File: doc/nott_pulse_scheduler.md
# nott_pulse_scheduler

Sequences and shares one clocked RSFQ inverting cell (NOT-T class: a clock pulse emits an output pulse only if no data pulse arrived since the previous clock) between several requesters. Each accepted request injects an optional data pulse, waits a setup interval, fires the cell clock, and captures the cell's output within a window. It returns the result and an inversion-check error flag to the requester. The block sits between the behavioural cell model and the test/control logic that exercises it.

## Interface
- NREQ, 2: number of requesters (2..8)
- SETUP_CYC, 2: cycles between data pulse and cell clock (≥1)
- WIN_CYC, 4: output capture window after cell clock, in cycles (≥1; also serves as hold time)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester request
- req_data  in  NREQ  per-requester data bit: 1 = inject a data pulse
- req_ready  out  NREQ  one-hot grant; handshake completes when valid & ready
- cell_in  out  1  one-cycle data pulse to cell
- cell_clk  out  1  one-cycle clock pulse to cell
- cell_out  in  1  output pulse from cell (one or more cycles high)
- rsp_valid  out  1  one-cycle response strobe, no backpressure
- rsp_id  out  $clog2(NREQ)  requester index of the response
- rsp_data  out  1  1 = cell output pulse seen in window
- rsp_err  out  1  1 = rsp_data equals the request's data bit (inversion failed)
- stray_pulse  out  1  sticky: cell_out high outside any capture window

## Operation
- States: IDLE, DATA, SETUP, CLOCK, CAPTURE, RESP.
- IDLE: round-robin arbiter asserts req_ready for exactly one valid requester, or none. On handshake, latch id and data, then go to DATA.
- DATA (1 cycle): cell_in = latched data. Go to SETUP.
- SETUP (SETUP_CYC cycles, down-counter): all cell outputs 0.
- CLOCK (1 cycle): cell_clk = 1. Clear capture flag. Go to CAPTURE.
- CAPTURE (WIN_CYC cycles): capture flag |= cell_out each cycle.
- RESP (1 cycle): rsp_valid = 1, with rsp_id, rsp_data = flag, rsp_err = (flag == data). Return to IDLE.
- req_ready is 0 in every state except IDLE, so only one transaction is ever in flight.
- Round-robin: priority starts at last-granted + 1, wrapping from NREQ-1 to 0. After reset, requester 0 has highest priority.
- A requester that drops valid before its grant loses nothing; no state is kept for it.
- cell_out high in any state other than CAPTURE sets stray_pulse. It stays set until reset and does not affect rsp_data.
- rsp_id, rsp_data and rsp_err are 0 whenever rsp_valid = 0.

## Timing
- Handshake at cycle 0 → cell_in at 1 → cell_clk at 2+SETUP_CYC → capture cycles 3+SETUP_CYC .. 2+SETUP_CYC+WIN_CYC → rsp_valid at 3+SETUP_CYC+WIN_CYC.
- With default parameters: cell_clk at 4, capture at 5..8, rsp_valid at 9. Earliest next handshake is at 10.
- A cell_out pulse in the same cycle as cell_clk does not count; capture begins the following cycle.
- Reset values (asynchronous on rst_n low): all outputs 0, state IDLE, arbiter pointer set so requester 0 is next, stray_pulse 0.
- Reset mid-transaction drops the transaction: no rsp_valid, and no cell_clk is issued afterwards.
- Outputs are registered; there are no combinational paths from inputs to cell_in, cell_clk or rsp_*. req_ready may depend combinationally on req_valid.

## Structure
- Package nott_sched_pkg holds the state enum and default parameter constants.
- Sub-module rr_arbiter (parameter NREQ) takes the request vector and an advance strobe, and produces a one-hot grant and grant index. The pointer updates only on handshake.
- The top level holds the FSM, the SETUP/WIN down-counter (width from max(SETUP_CYC, WIN_CYC)), and the latches for id, data and capture flag.

## Test plan
- Single request, req 0, data=1, cell model behaves correctly (no output) → cell_in at 1, cell_clk at 4, rsp_valid at 9 with id=0, data=0, err=0.
- Req 1, data=0, cell pulses at cycle 6 → rsp at 9: id=1, data=1, err=0.
- Both valid continuously from reset → grants in order 0, 1, 0, 1, each 10 cycles apart, with exactly one req_ready bit high in IDLE.
- Faulty cell: data=1 yet cell pulses at 5 → rsp_data=1, rsp_err=1.
- cell_out pulse at cycle 2 (SETUP) and at cycle 4 (CLOCK cycle) → stray_pulse=1 from the cycle after each, and rsp_data is unaffected.
- rst_n low at cycle 3 for one cycle → all outputs 0 immediately, no cell_clk or rsp; a new request is granted to requester 0 first.
